// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [31:0] cnt_max;
        logic [31:0] mid;
    } baud_cfg_t;

    // Bit period in sys_clk cycles and the centre sample point within it.
    function automatic baud_cfg_t baud_cfg(input int unsigned clk_freq, input int unsigned bps);
        baud_cfg_t cfg;
        cfg.cnt_max = 32'(clk_freq / bps);
        cfg.mid     = 32'((clk_freq / bps) / 2);
        return cfg;
    endfunction

    // Parity bit the transmitter should have sent; unused upper bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_maj3_sampler.sv
// RX synchroniser, falling-edge detect and 3-sample majority vote around the bit centre.
module uart_maj3_sampler #(
    parameter int unsigned CNT_W = 9,
    parameter int unsigned MID   = 217
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             rx,
    input  logic [CNT_W-1:0] baud_cnt,
    output logic             start_fall,
    output logic             bit_val,
    output logic             bit_tick
);

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic samp_a;
    logic samp_b;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // First two votes are captured early; the third is the live sample at the tick.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (baud_cnt == CNT_W'(MID - 1)) samp_a <= rx_sync;
            if (baud_cnt == CNT_W'(MID))     samp_b <= rx_sync;
        end
    end

    assign start_fall = rx_prev & ~rx_sync;
    assign bit_tick   = (baud_cnt == CNT_W'(MID + 1));
    assign bit_val    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with valid/ready output and framing/parity/overrun status.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS   = 115200,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_valid,
    input  logic                 po_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam baud_cfg_t   BAUD_CFG     = baud_cfg(CLK_FREQ, UART_BPS);
    localparam int unsigned BAUD_CNT_MAX = BAUD_CFG.cnt_max;
    localparam int unsigned MID          = BAUD_CFG.mid;
    localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);
    localparam int unsigned BIT_W        = 3;

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_frame: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
    end
    if (BAUD_CNT_MAX < 4) begin : g_bad_baud
        $error("uart_rx_frame: CLK_FREQ/UART_BPS too small for 3-sample voting");
    end

    rx_state_e            state_q;
    rx_state_e            state_d;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_err;
    logic                 start_fall;
    logic                 bit_val;
    logic                 bit_tick;
    logic                 shift_c;
    logic                 stop_tick_c;
    logic                 load_c;
    logic                 accept_c;
    logic                 drop_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_tick_c;
    logic                 par_err_q;
`endif

    uart_maj3_sampler #(
        .CNT_W (CNT_W),
        .MID   (MID)
    ) u_sampler (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx         (rx),
        .baud_cnt   (baud_cnt),
        .start_fall (start_fall),
        .bit_val    (bit_val),
        .bit_tick   (bit_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        shift_c     = 1'b0;
        stop_tick_c = 1'b0;
        load_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_tick_c  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_fall) state_d = START;
            end
            START: begin
                if (bit_tick) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_c = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    par_tick_c = 1'b1;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at the last stop-bit centre so the next start edge is not missed.
                if (bit_tick) begin
                    stop_tick_c = 1'b1;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        load_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept_c = load_c & ~(po_valid & ~po_ready);
    assign drop_c   = load_c &  (po_valid & ~po_ready);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_q == IDLE)               baud_cnt <= '0;
        else if (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1)) baud_cnt <= '0;
        else                                           baud_cnt <= baud_cnt + CNT_W'(1);
    end

    // Bit index within the current state; restarts on every state change.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_d != state_q) bit_cnt <= '0;
        else if (shift_c || stop_tick_c)   bit_cnt <= bit_cnt + BIT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)      shreg <= '0;
        else if (shift_c) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_q != STOP)  stop_err <= 1'b0;
        else if (stop_tick_c && !bit_val) stop_err <= 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            po_data   <= '0;
            po_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop_c;
            if (accept_c) begin
                po_data   <= shreg;
                po_valid  <= 1'b1;
                frame_err <= stop_err | ~bit_val;
            end else if (po_valid && po_ready) begin
                po_valid  <= 1'b0;
                frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_q == START) par_err_q <= 1'b0;
        else if (par_tick_c)             par_err_q <= (bit_val != parity_bit(8'(shreg), PARITY_ODD != 0));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)                     parity_err <= 1'b0;
        else if (accept_c)               parity_err <= par_err_q;
        else if (po_valid && po_ready)   parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 default instance and a 7-bit, 2-stop-bit instance.
module tb_uart_rx_frame;

    localparam int unsigned B0 = 434;
    localparam int unsigned B1 = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned P1 = 1;
`else
    localparam int unsigned P1 = 0;
`endif
    localparam int unsigned FRAME1 = 1 + 7 + P1 + 2;
    localparam int unsigned LAT0   = 3 + 9 * B0 + (B0 / 2 + 1) + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       v0, fe0, pe0, ov0;
    logic       v1, fe1, pe1, ov1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   checks = 0, errors = 0;
    int   words0 = 0, words1 = 0, ovr0 = 0, ovr1 = 0;

    always #5 sys_clk = ~sys_clk;

    uart_rx_frame dut0 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx         (rx0),
        .po_data    (data0),
        .po_valid   (v0),
        .po_ready   (rdy0),
        .frame_err  (fe0),
        .parity_err (pe0),
        .overrun    (ov0)
    );

    uart_rx_frame #(
        .UART_BPS   (100_000),
        .CLK_FREQ   (1_600_000),
        .DATA_BITS  (7),
        .STOP_BITS  (2),
        .PARITY_ODD (0)
    ) dut1 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx         (rx1),
        .po_data    (data1),
        .po_valid   (v1),
        .po_ready   (rdy1),
        .frame_err  (fe1),
        .parity_err (pe1),
        .overrun    (ov1)
    );

    // Handshake monitor: every accepted word is compared against the scoreboard head.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (ov0) ovr0++;
            if (ov1) ovr1++;
            if (v0 && rdy0) begin
                words0++;
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL word0_unexpected: got data=%h fe=%b pe=%b, required no word", data0, fe0, pe0);
                end else begin
                    m0 = q0.pop_front();
                    if ({data0, fe0, pe0} !== {m0.d, m0.fe, m0.pe}) begin
                        errors++;
                        $display("FAIL word0: got data=%h fe=%b pe=%b, required data=%h fe=%b pe=%b",
                                 data0, fe0, pe0, m0.d, m0.fe, m0.pe);
                    end
                end
            end
            if (v1 && rdy1) begin
                words1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL word1_unexpected: got data=%h fe=%b pe=%b, required no word", data1, fe1, pe1);
                end else begin
                    m1 = q1.pop_front();
                    if ({1'b0, data1, fe1, pe1} !== {m1.d, m1.fe, m1.pe}) begin
                        errors++;
                        $display("FAIL word1: got data=%h fe=%b pe=%b, required data=%h fe=%b pe=%b",
                                 data1, fe1, pe1, m1.d, m1.fe, m1.pe);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic send_bits(input int which, input logic [15:0] bits, input int n, input int baud);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i];
            else            rx1 = bits[i];
            tick(baud);
        end
    endtask

    task automatic send0(input logic [7:0] d);
        logic [15:0] f;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[8:1] = d;
        send_bits(0, f, 10, B0);
    endtask

    task automatic send1(input logic [6:0] d, input logic par, input logic s1, input logic s2);
        logic [15:0] f;
        int          idx;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[7:1] = d;
        idx    = 8;
`ifdef UART_RX_PARITY_EN
        f[8]   = par;
        idx    = 9;
`endif
        f[idx]     = s1;
        f[idx + 1] = s2;
        send_bits(1, f, idx + 2, B1);
        rx1 = 1'b1;
    endtask

    task automatic wait_drain(input int which, input int budget, output bit ok);
        int n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            tick(1);
            n++;
        end
        ok = ((which == 0) ? q0.size() : q1.size()) == 0;
        tick(2);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(3);
        checks++;
        if ({data0, v0, fe0, pe0, ov0} !== 12'h000) begin
            errors++;
            $display("FAIL reset0: got data=%h v=%b fe=%b pe=%b ov=%b, required all 0", data0, v0, fe0, pe0, ov0);
        end
        checks++;
        if ({data1, v1, fe1, pe1, ov1} !== 11'h000) begin
            errors++;
            $display("FAIL reset1: got data=%h v=%b fe=%b pe=%b ov=%b, required all 0", data1, v1, fe1, pe1, ov1);
        end
        sys_rst = 1'b0;
        tick(5);
    endtask

    task automatic test_8n1();
        int w = words0;
        int lat = 0;
        bit seen = 1'b0;
        bit ok;
        rdy0 = 1'b1;
        q0.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
        fork
            send0(8'hA5);
            begin
                while (!seen && lat < 6000) begin
                    @(posedge sys_clk);
                    #1;
                    lat++;
                    seen = v0;
                end
            end
        join
        checks++;
        if (!seen || lat != LAT0) begin
            errors++;
            $display("FAIL latency_8n1: got %0d cycles (seen=%b), required %0d", lat, seen, LAT0);
        end
        wait_drain(0, 2 * B0, ok);
        checks++;
        if (!ok || words0 - w != 1) begin
            errors++;
            $display("FAIL words_8n1: got %0d words (drained=%b), required 1", words0 - w, ok);
        end
    endtask

    task automatic test_glitch();
        int w = words0;
        bit ok;
        rx0 = 1'b0;
        tick(100);
        rx0 = 1'b1;
        tick(2 * B0);
        checks++;
        if (words0 != w || {v0, fe0, pe0, ov0} !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_silent: got words=%0d v=%b fe=%b pe=%b ov=%b, required none", words0 - w, v0, fe0, pe0, ov0);
        end
        q0.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
        send0(8'h3C);
        wait_drain(0, 2 * B0, ok);
        checks++;
        if (!ok || words0 - w != 1) begin
            errors++;
            $display("FAIL glitch_then_word: got %0d words (drained=%b), required 1", words0 - w, ok);
        end
    endtask

    task automatic test_overrun();
        int w = words0;
        int o = ovr0;
        rdy0 = 1'b0;
        q0.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send0(8'h11);
        send0(8'h22);
        tick(B0);
        checks++;
        if (v0 !== 1'b1 || data0 !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold: got v=%b data=%h, required v=1 data=11", v0, data0);
        end
        checks++;
        if (ovr0 - o != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d, required 1", ovr0 - o);
        end
        rdy0 = 1'b1;
        tick(1);
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_release: got v=%b, required 0", v0);
        end
        tick(2 * B0);
        checks++;
        if (words0 - w != 1 || q0.size() != 0) begin
            errors++;
            $display("FAIL overrun_words: got %0d words, %0d pending, required 1 and 0", words0 - w, q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int w = words0;
        int o = ovr0;
        bit ok;
        logic [7:0] pat [3];
        pat[0] = 8'h55;
        pat[1] = 8'h00;
        pat[2] = 8'hFF;
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{d: pat[i], fe: 1'b0, pe: 1'b0});
            send0(pat[i]);
        end
        wait_drain(0, 2 * B0, ok);
        checks++;
        if (!ok || words0 - w != 3 || ovr0 != o) begin
            errors++;
            $display("FAIL back_to_back: got %0d words, %0d overruns, drained=%b, required 3 and 0", words0 - w, ovr0 - o, ok);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        bit ok;
        rdy0 = 1'b0;
        send0(8'h77);
        tick(B0);
        checks++;
        if (v0 !== 1'b1 || data0 !== 8'h77) begin
            errors++;
            $display("FAIL reset_mid_pre: got v=%b data=%h, required v=1 data=77", v0, data0);
        end
        rx0 = 1'b0;
        tick(4 * B0);
        sys_rst = 1'b1;
        rx0 = 1'b1;
        tick(1);
        checks++;
        if ({data0, v0, fe0, pe0, ov0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got data=%h v=%b fe=%b pe=%b ov=%b, required all 0", data0, v0, fe0, pe0, ov0);
        end
        sys_rst = 1'b0;
        tick(2 * B0);
        rdy0 = 1'b1;
        w = words0;
        q0.push_back('{d: 8'hC3, fe: 1'b0, pe: 1'b0});
        send0(8'hC3);
        wait_drain(0, 2 * B0, ok);
        checks++;
        if (!ok || words0 - w != 1) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d words (drained=%b), required 1", words0 - w, ok);
        end
    endtask

    task automatic test_stop2_parity();
        int w = words1;
        int exp_n = 2;
        bit ok;
        logic p;
        rdy1 = 1'b1;
        p = ^(7'h41);
        q1.push_back('{d: 8'h41, fe: 1'b1, pe: 1'b0});
        send1(7'h41, p, 1'b1, 1'b0);
        tick(B1);
`ifdef UART_RX_PARITY_EN
        q1.push_back('{d: 8'h41, fe: 1'b0, pe: 1'b1});
        send1(7'h41, ~p, 1'b1, 1'b1);
        tick(B1);
        exp_n = 3;
`endif
        q1.push_back('{d: 8'h41, fe: 1'b0, pe: 1'b0});
        send1(7'h41, p, 1'b1, 1'b1);
        wait_drain(1, 4 * B1, ok);
        checks++;
        if (!ok || words1 - w != exp_n) begin
            errors++;
            $display("FAIL stop2_words: got %0d words (drained=%b), required %0d", words1 - w, ok, exp_n);
        end
    endtask

    task automatic test_break();
        int w = words1;
        bit ok;
        q1.push_back('{d: 8'h00, fe: 1'b1, pe: 1'b0});
        rx1 = 1'b0;
        tick(3 * FRAME1 * B1);
        checks++;
        if (words1 - w != 1) begin
            errors++;
            $display("FAIL break_single: got %0d words, required 1", words1 - w);
        end
        rx1 = 1'b1;
        tick(3 * B1);
        checks++;
        if (words1 - w != 1 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL break_rearm_quiet: got %0d words v=%b, required 1 and v=0", words1 - w, v1);
        end
        q1.push_back('{d: 8'h2A, fe: 1'b0, pe: 1'b0});
        send1(7'h2A, ^(7'h2A), 1'b1, 1'b1);
        wait_drain(1, 4 * B1, ok);
        checks++;
        if (!ok || words1 - w != 2) begin
            errors++;
            $display("FAIL break_after: got %0d words (drained=%b), required 2", words1 - w, ok);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_stop2_parity();
        test_break();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
